// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX resolve/train,
// plus control-flow and mispredict statistics.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [PC_W-1:0] i_pc_if,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_pred_pc,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_branch,
    input  logic            i_ex_is_jump,
    input  logic [PC_W-1:0] i_ex_pc,
    input  logic            i_ex_taken,
    input  logic [PC_W-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    input  logic [PC_W-1:0] i_ex_pred_pc,
    output logic            o_mispredict,
    output logic [PC_W-1:0] o_redirect_pc,
    output logic [CNT_W-1:0] o_stat_ctrl,
    output logic [CNT_W-1:0] o_stat_miss
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [CNT_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, ctl;
    logic             wr_en, wr_valid;
    logic [PC_W-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    assign if_idx = i_pc_if[IDX_W+1:2];
    assign if_tag = i_pc_if[PC_W-1:IDX_W+2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];
    assign ex_tag = i_ex_pc[PC_W-1:IDX_W+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign o_pred_taken = if_hit & ctr_q[if_idx][1];
    assign o_pred_pc    = o_pred_taken ? target_q[if_idx]
                                       : i_pc_if + PC_W'(4);

    assign ctl = i_ex_valid & (i_ex_is_branch | i_ex_is_jump);

    // A non-control instruction predicted taken means the BTB aliased.
    always_comb begin
        o_mispredict = 1'b0;
        if (ctl)
            o_mispredict = (i_ex_pred_taken != i_ex_taken) |
                           (i_ex_taken & (i_ex_pred_pc != i_ex_target));
        else if (i_ex_valid)
            o_mispredict = i_ex_pred_taken;
    end

    assign o_redirect_pc = !o_mispredict ? '0 :
                           (ctl & i_ex_taken) ? i_ex_target
                                              : i_ex_pc + PC_W'(4);

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = 1'b1;
        wr_target = target_q[ex_idx];
        wr_ctr    = ctr_q[ex_idx];
        if (i_ex_valid) begin
            if (i_ex_is_jump) begin
                wr_en     = 1'b1;
                wr_target = i_ex_target;
                wr_ctr    = 2'b11;
            end else if (i_ex_is_branch) begin
                if (ex_hit && i_ex_taken) begin
                    wr_en     = 1'b1;
                    wr_target = i_ex_target;
                    wr_ctr    = (ctr_q[ex_idx] == 2'b11) ? 2'b11
                                : ctr_q[ex_idx] + 2'd1;
                end else if (ex_hit) begin
                    wr_en  = 1'b1;
                    wr_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00
                             : ctr_q[ex_idx] - 2'd1;
                end else if (i_ex_taken) begin
                    wr_en     = 1'b1;
                    wr_target = i_ex_target;
                    wr_ctr    = 2'b10;
                end
            end else if (ex_hit && i_ex_pred_taken) begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    assign ctrl_d = ctl ? ctrl_q + CNT_W'(1) : ctrl_q;
    assign miss_d = o_mispredict ? miss_q + CNT_W'(1) : miss_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            ctrl_q <= '0;
            miss_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[ex_idx]  <= wr_valid;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= wr_target;
                ctr_q[ex_idx]    <= wr_ctr;
            end
            ctrl_q <= ctrl_d;
            miss_q <= miss_d;
        end
    end

    assign o_stat_ctrl = ctrl_q;
    assign o_stat_miss = miss_q;
endmodule
